// File: rtl/lc3b_scoreboard.sv
// Register/CC pending-write scoreboard for the LC-3b decode stage.
// Each architectural register and the condition codes carry a counter of
// in-flight writes; decode stalls while a needed source (or the CC for a
// conditional branch) still has an outstanding write.
module lc3b_scoreboard #(
  parameter int NUM_REGS  = 8,
  parameter int REG_W     = 3,
  parameter int NUM_SRC   = 2,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dec_valid,
  input  logic [NUM_SRC*REG_W-1:0] dec_sr,
  input  logic [NUM_SRC-1:0]       dec_sr_needed,
  input  logic                     dec_br_cc,
  input  logic                     dec_ld_reg,
  input  logic [REG_W-1:0]         dec_drid,
  input  logic                     dec_ld_cc,
  input  logic                     issue,
  input  logic                     wb_valid,
  input  logic                     wb_ld_reg,
  input  logic [REG_W-1:0]         wb_drid,
  input  logic                     wb_ld_cc,
  input  logic                     kill_valid,
  input  logic                     kill_ld_reg,
  input  logic [REG_W-1:0]         kill_drid,
  input  logic                     kill_ld_cc,
  output logic                     dep_stall,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic                     cc_busy,
  output logic                     sb_err
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  logic [CNT_W-1:0]    r_cc_cnt;
  logic                r_sb_err;

  logic [1:0]          w_dec_r [NUM_REGS];
  logic [1:0]          w_dec_cc;
  logic [NUM_REGS-1:0] w_busy_eff;
  logic                w_cc_busy_eff;
  logic                w_dep_stall;
  logic                w_fire;
  logic [CNT_W-1:0]    w_cnt_nxt [NUM_REGS];
  logic [CNT_W-1:0]    w_cc_nxt;
  logic                w_uflow;

  // Counter plus issue increment minus retire/kill decrement, in a width that
  // can represent the negative (underflow) case.
  function automatic logic signed [CNT_W+1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                       input logic inc,
                                                       input logic [1:0] dec);
    cnt_step = $signed({2'b00, cnt}) + $signed({{(CNT_W+1){1'b0}}, inc})
             - $signed({{CNT_W{1'b0}}, dec});
  endfunction

  // Negative results clamp to zero; the caller flags the underflow.
  function automatic logic [CNT_W-1:0] cnt_clamp(input logic signed [CNT_W+1:0] s);
    cnt_clamp = s[CNT_W+1] ? '0 : s[CNT_W-1:0];
  endfunction

  // Retire/kill decrements and the effective busy view used by the hazard check.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_dec_r[r] = {1'b0, wb_valid & wb_ld_reg & (wb_drid == REG_W'(r))}
                 + {1'b0, kill_valid & kill_ld_reg & (kill_drid == REG_W'(r))};
      if (WB_BYPASS != 0)
        w_busy_eff[r] = ({2'b00, r_cnt[r]} > {{CNT_W{1'b0}}, w_dec_r[r]});
      else
        w_busy_eff[r] = (r_cnt[r] != '0);
      busy_vec[r] = (r_cnt[r] != '0);
    end
    w_dec_cc = {1'b0, wb_valid & wb_ld_cc} + {1'b0, kill_valid & kill_ld_cc};
    if (WB_BYPASS != 0)
      w_cc_busy_eff = ({2'b00, r_cc_cnt} > {{CNT_W{1'b0}}, w_dec_cc});
    else
      w_cc_busy_eff = (r_cc_cnt != '0);
  end

  // Decode stall: RAW on sources or CC, plus counter saturation on the destination.
  always_comb begin
    w_dep_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (dec_sr_needed[i] && (dec_sr[i*REG_W +: REG_W] == REG_W'(r)) && w_busy_eff[r])
          w_dep_stall = 1'b1;
      end
    end
    if (dec_br_cc && w_cc_busy_eff)
      w_dep_stall = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (dec_ld_reg && (dec_drid == REG_W'(r)) && (r_cnt[r] == MAX) && (w_dec_r[r] == 2'd0))
        w_dep_stall = 1'b1;
    end
    if (dec_ld_cc && (r_cc_cnt == MAX) && (w_dec_cc == 2'd0))
      w_dep_stall = 1'b1;
    w_dep_stall = w_dep_stall & dec_valid;
    w_fire      = issue & dec_valid & ~w_dep_stall;
  end

  // Next counter values; a net negative step marks an underflow.
  always_comb begin
    logic signed [CNT_W+1:0] w_sum;
    w_uflow = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_sum        = cnt_step(r_cnt[r], w_fire & dec_ld_reg & (dec_drid == REG_W'(r)), w_dec_r[r]);
      w_cnt_nxt[r] = cnt_clamp(w_sum);
      w_uflow      = w_uflow | w_sum[CNT_W+1];
    end
    w_sum    = cnt_step(r_cc_cnt, w_fire & dec_ld_cc, w_dec_cc);
    w_cc_nxt = cnt_clamp(w_sum);
    w_uflow  = w_uflow | w_sum[CNT_W+1];
  end

  // Counter and sticky error state; reset discards all pending writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_cc_cnt <= '0;
      r_sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= w_cnt_nxt[r];
      r_cc_cnt <= w_cc_nxt;
      r_sb_err <= r_sb_err | w_uflow;
    end
  end

  assign dep_stall = w_dep_stall;
  assign cc_busy   = (r_cc_cnt != '0);
  assign sb_err    = r_sb_err;

endmodule

// File: tb/tb_lc3b_scoreboard.sv
// Scoreboard bench for lc3b_scoreboard: two instances (bypass on / off) share
// stimulus; a reference model of outstanding writes predicts every cycle.
module tb_lc3b_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dec_valid, dec_br_cc, dec_ld_reg, dec_ld_cc, issue;
  logic [5:0] dec_sr;
  logic [1:0] dec_sr_needed;
  logic [2:0] dec_drid, wb_drid, kill_drid;
  logic       wb_valid, wb_ld_reg, wb_ld_cc;
  logic       kill_valid, kill_ld_reg, kill_ld_cc;

  logic       stall_b, stall_n, ccb_b, ccb_n, err_b, err_n;
  logic [7:0] bv_b, bv_n;

  always #5 clk = ~clk;

  lc3b_scoreboard #(.NUM_REGS(8), .REG_W(3), .NUM_SRC(2), .CNT_W(2), .WB_BYPASS(1)) u_byp (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_sr(dec_sr),
    .dec_sr_needed(dec_sr_needed), .dec_br_cc(dec_br_cc), .dec_ld_reg(dec_ld_reg),
    .dec_drid(dec_drid), .dec_ld_cc(dec_ld_cc), .issue(issue), .wb_valid(wb_valid),
    .wb_ld_reg(wb_ld_reg), .wb_drid(wb_drid), .wb_ld_cc(wb_ld_cc), .kill_valid(kill_valid),
    .kill_ld_reg(kill_ld_reg), .kill_drid(kill_drid), .kill_ld_cc(kill_ld_cc),
    .dep_stall(stall_b), .busy_vec(bv_b), .cc_busy(ccb_b), .sb_err(err_b));

  lc3b_scoreboard #(.NUM_REGS(8), .REG_W(3), .NUM_SRC(2), .CNT_W(2), .WB_BYPASS(0)) u_nobyp (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_sr(dec_sr),
    .dec_sr_needed(dec_sr_needed), .dec_br_cc(dec_br_cc), .dec_ld_reg(dec_ld_reg),
    .dec_drid(dec_drid), .dec_ld_cc(dec_ld_cc), .issue(issue), .wb_valid(wb_valid),
    .wb_ld_reg(wb_ld_reg), .wb_drid(wb_drid), .wb_ld_cc(wb_ld_cc), .kill_valid(kill_valid),
    .kill_ld_reg(kill_ld_reg), .kill_drid(kill_drid), .kill_ld_cc(kill_ld_cc),
    .dep_stall(stall_n), .busy_vec(bv_n), .cc_busy(ccb_n), .sb_err(err_n));

  typedef struct packed {
    logic [1:0]  stall;
    logic [15:0] bv;
    logic [1:0]  ccb;
    logic [1:0]  err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: outstanding writes per register / CC for [0]=bypass, [1]=no bypass.
  int   m_cnt [2][8];
  int   m_cc  [2];
  bit   m_err [2];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("dep_stall_byp",   {7'd0, stall_b}, {7'd0, mon_e.stall[0]});
      chk("dep_stall_nobyp", {7'd0, stall_n}, {7'd0, mon_e.stall[1]});
      chk("busy_vec_byp",    bv_b, mon_e.bv[7:0]);
      chk("busy_vec_nobyp",  bv_n, mon_e.bv[15:8]);
      chk("cc_busy_byp",     {7'd0, ccb_b}, {7'd0, mon_e.ccb[0]});
      chk("cc_busy_nobyp",   {7'd0, ccb_n}, {7'd0, mon_e.ccb[1]});
      chk("sb_err_byp",      {7'd0, err_b}, {7'd0, mon_e.err[0]});
      chk("sb_err_nobyp",    {7'd0, err_n}, {7'd0, mon_e.err[1]});
    end
  end

  // Predict this cycle's outputs from the current inputs, push them, then
  // advance the model across the next rising edge.
  task automatic step();
    exp_t e;
    int   ret [8];
    int   retcc, v;
    bit   stall, fire, byp, busy;
    int   nc  [2][8];
    int   ncc [2];
    bit   nerr[2];
    e = '0;
    for (int b = 0; b < 2; b++) begin
      byp = (b == 0);
      if (!reset_n) begin
        for (int r = 0; r < 8; r++) m_cnt[b][r] = 0;
        m_cc[b]  = 0;
        m_err[b] = 1'b0;
      end
      for (int r = 0; r < 8; r++)
        ret[r] = ((wb_valid && wb_ld_reg && wb_drid == r) ? 1 : 0)
               + ((kill_valid && kill_ld_reg && kill_drid == r) ? 1 : 0);
      retcc = ((wb_valid && wb_ld_cc) ? 1 : 0) + ((kill_valid && kill_ld_cc) ? 1 : 0);
      stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
        v    = int'(dec_sr[i*3 +: 3]);
        busy = byp ? (m_cnt[b][v] > ret[v]) : (m_cnt[b][v] > 0);
        if (dec_sr_needed[i] && busy) stall = 1'b1;
      end
      busy = byp ? (m_cc[b] > retcc) : (m_cc[b] > 0);
      if (dec_br_cc && busy) stall = 1'b1;
      if (dec_ld_reg && m_cnt[b][int'(dec_drid)] == 3 && ret[int'(dec_drid)] == 0) stall = 1'b1;
      if (dec_ld_cc && m_cc[b] == 3 && retcc == 0) stall = 1'b1;
      stall = stall && dec_valid && reset_n;
      fire  = issue && dec_valid && !stall;
      e.stall[b] = stall;
      e.ccb[b]   = (m_cc[b] != 0);
      e.err[b]   = m_err[b];
      nerr[b]    = m_err[b];
      for (int r = 0; r < 8; r++) begin
        e.bv[b*8 + r] = (m_cnt[b][r] != 0);
        v = m_cnt[b][r] + ((fire && dec_ld_reg && dec_drid == r) ? 1 : 0) - ret[r];
        if (v < 0) begin v = 0; nerr[b] = 1'b1; end
        nc[b][r] = reset_n ? v : 0;
      end
      v = m_cc[b] + ((fire && dec_ld_cc) ? 1 : 0) - retcc;
      if (v < 0) begin v = 0; nerr[b] = 1'b1; end
      ncc[b]  = reset_n ? v : 0;
      nerr[b] = nerr[b] && reset_n;
    end
    exp_q.push_back(e);
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 8; r++) m_cnt[b][r] = nc[b][r];
      m_cc[b]  = ncc[b];
      m_err[b] = nerr[b];
    end
    #1;
  endtask

  task automatic clr();
    dec_valid = 0; dec_sr = '0; dec_sr_needed = '0; dec_br_cc = 0; dec_ld_reg = 0;
    dec_drid = '0; dec_ld_cc = 0; issue = 0; wb_valid = 0; wb_ld_reg = 0; wb_drid = '0;
    wb_ld_cc = 0; kill_valid = 0; kill_ld_reg = 0; kill_drid = '0; kill_ld_cc = 0;
  endtask

  task automatic do_reset();
    clr();
    reset_n = 0;
    step();
    reset_n = 1;
  endtask

  initial begin
    clr();
    reset_n = 0;
    @(posedge clk); #1;
    step(); step();
    reset_n = 1;

    // ADD R1 <- R2,R3 then R4 <- R1, retired while decoding
    dec_valid = 1; issue = 1; dec_ld_reg = 1; dec_drid = 1;
    dec_sr = {3'd3, 3'd2}; dec_sr_needed = 2'b11;
    step();
    dec_sr = {3'd0, 3'd1}; dec_sr_needed = 2'b01; dec_drid = 4;
    step();
    wb_valid = 1; wb_ld_reg = 1; wb_drid = 1;
    step();
    wb_valid = 0; wb_ld_reg = 0;
    step();
    clr(); step(); step();

    // saturation on R5
    do_reset();
    dec_valid = 1; issue = 1; dec_ld_reg = 1; dec_drid = 5;
    repeat (4) step();
    wb_valid = 1; wb_ld_reg = 1; wb_drid = 5;
    step();
    dec_valid = 0; issue = 0;
    repeat (3) step();
    clr(); step();

    // CC producer, dependent branch, producer squashed
    do_reset();
    dec_valid = 1; issue = 1; dec_ld_cc = 1;
    step();
    dec_ld_cc = 0; dec_br_cc = 1;
    step();
    kill_valid = 1; kill_ld_cc = 1;
    step();
    kill_valid = 0; kill_ld_cc = 0;
    step(); step();

    // underflow on R6, sticky until reset
    do_reset();
    wb_valid = 1; wb_ld_reg = 1; wb_drid = 6;
    step();
    clr();
    repeat (3) step();
    do_reset();
    step();

    // reset asserted between edges while R1 has two pending writes
    dec_valid = 1; issue = 1; dec_ld_reg = 1; dec_drid = 1;
    step(); step();
    dec_ld_reg = 0; issue = 0; dec_sr = {3'd0, 3'd1}; dec_sr_needed = 2'b01;
    step();
    reset_n = 0;
    step();
    reset_n = 1;
    clr(); step();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      int r;
      if (c % 150 == 0) do_reset();
      dec_valid     = ($urandom_range(3) != 0);
      dec_sr        = 6'($urandom);
      dec_sr_needed = 2'($urandom);
      dec_br_cc     = ($urandom_range(4) == 0);
      dec_ld_reg    = $urandom_range(1);
      dec_drid      = 3'($urandom);
      dec_ld_cc     = ($urandom_range(2) == 0);
      issue         = ($urandom_range(4) != 0);
      r             = $urandom_range(7);
      wb_valid      = ($urandom_range(1) == 0);
      wb_drid       = 3'(r);
      wb_ld_reg     = (m_cnt[0][r] > 0 && m_cnt[1][r] > 0) || ($urandom_range(31) == 0);
      wb_ld_cc      = (m_cc[0] > 0 && m_cc[1] > 0 && $urandom_range(1) == 0);
      r             = $urandom_range(7);
      kill_valid    = ($urandom_range(4) == 0);
      kill_drid     = 3'(r);
      kill_ld_reg   = (m_cnt[0][r] > 1 && m_cnt[1][r] > 1) || ($urandom_range(63) == 0);
      kill_ld_cc    = (m_cc[0] > 1 && m_cc[1] > 1);
      step();
    end
    clr(); step();

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3b_scoreboard.md
Name: lc3b_scoreboard

Overview:
- Parametrised register/CC scoreboard that replaces per-stage destination comparison with per-register pending-write counters.
- Sits beside the decode stage. Increments on issue; decrements on writeback retire or on squash of an issued instruction.
- Produces the decode dep_stall, so the hazard check is independent of pipeline depth.
- Optional same-cycle writeback bypass, counter-saturation stall and a sticky underflow error flag.

Parameters:
- NUM_REGS, 8, number of architectural registers tracked
- REG_W, 3, register id width; must equal $clog2(NUM_REGS)
- NUM_SRC, 2, source operands checked per decoded instruction
- CNT_W, 2, pending-write counter width per register and for CC; saturation value MAX = 2^CNT_W-1
- WB_BYPASS, 1, 1 = a write retiring this cycle clears the hazard in the same cycle; 0 = clears one cycle later

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode holds a valid instruction
- dec_sr  in  NUM_SRC*REG_W  source ids; source i = bits [i*REG_W +: REG_W]
- dec_sr_needed  in  NUM_SRC  source i is read
- dec_br_cc  in  1  decoded instruction is a conditional branch needing settled CC (opcode br with branch_stall)
- dec_ld_reg  in  1  decoded instruction writes dec_drid
- dec_drid  in  REG_W  destination id
- dec_ld_cc  in  1  decoded instruction writes CC
- issue  in  1  pipeline advances decode this cycle (pipeline stall already folded in)
- wb_valid  in  1  writeback instruction retires this cycle
- wb_ld_reg  in  1  retiring instruction writes wb_drid
- wb_drid  in  REG_W  retiring destination
- wb_ld_cc  in  1  retiring instruction writes CC
- kill_valid  in  1  an issued, not-yet-retired instruction is squashed this cycle
- kill_ld_reg  in  1  squashed instruction had ld_reg
- kill_drid  in  REG_W  squashed destination
- kill_ld_cc  in  1  squashed instruction had ld_cc
- dep_stall  out  1  decode must not advance
- busy_vec  out  NUM_REGS  bit r = cnt[r] != 0 (registered state, no bypass)
- cc_busy  out  1  cc_cnt != 0
- sb_err  out  1  sticky underflow error

Behaviour:
- State: cnt[0..NUM_REGS-1] and cc_cnt, each CNT_W bits; sb_err, 1 bit.
- Reset (reset_n=0, asynchronous): all counters 0, sb_err=0. Outputs then read dep_stall=0, busy_vec=0, cc_busy=0, sb_err=0. Reset mid-operation discards all pending state.
- Retire/kill term per register r:
  - dec_r = (wb_valid & wb_ld_reg & wb_drid==r) + (kill_valid & kill_ld_reg & kill_drid==r), range 0..2.
  - CC uses the same form with the ld_cc bits.
- Effective busy for hazard check:
  - WB_BYPASS=1: cnt[r] > dec_r.
  - WB_BYPASS=0: cnt[r] != 0.
  - CC follows the same rule.
- dep_stall is combinational and asserts only when dec_valid=1, if any of:
  - any i with dec_sr_needed[i] and source i effectively busy;
  - dec_br_cc and CC effectively busy;
  - dec_ld_reg and cnt[dec_drid]==MAX with no retire/kill of dec_drid this cycle (saturation stall);
  - dec_ld_cc and cc_cnt==MAX with no CC retire/kill this cycle.
- No dependency on dec_drid except saturation. WAW is permitted because the pipeline is in-order.
- fire = issue & dec_valid & ~dep_stall. issue while dep_stall=1 is ignored, with no state change.
- Next state: cnt[r] <= cnt[r] + (fire & dec_ld_reg & dec_drid==r) - dec_r. Compute in CNT_W+2 bit signed width.
  - Negative result: clamp to 0 and set sb_err.
  - Overflow is unreachable because of the saturation stall.
- cc_cnt uses the same rule with the ld_cc terms.
- Simultaneous inc and dec on the same register: net change 0, no stall.
- sb_err is cleared only by reset.
- Latency: issue updates counters at the next edge; dep_stall for a dependent instruction in the following cycle reflects it.

Test Plan:
- After reset, issue ADD R1←R2,R3 (dec_ld_reg=1, dec_drid=1) → next cycle busy_vec=8'h02. Decode R4←R1 (sr_needed=01, sr=R1) → dep_stall=1. Retire wb_drid=1 with WB_BYPASS=1 → dep_stall=0 in the retire cycle; busy_vec=0 next cycle.
- WB_BYPASS=0, same sequence → dep_stall=1 in the retire cycle, 0 one cycle later.
- Issue three writes to R5 without retire (CNT_W=2) → cnt[5]=3; a fourth write to R5 gets dep_stall=1 and the counter stays 3. Retire one R5 in the same cycle as that fourth decode → fire=1, cnt[5] stays 3.
- Issue an ld_cc instruction, then a branch with dec_br_cc=1 → dep_stall=1, cc_busy=1. kill_valid with kill_ld_cc=1 → cc_busy=0 next cycle and the branch fires.
- wb_valid with wb_ld_reg=1, wb_drid=6 while cnt[6]=0 → cnt[6] stays 0 and sb_err=1 persists until reset_n pulses low.
- Assert reset_n=0 mid-cycle with cnt[1]=2 → busy_vec=0 and dep_stall=0 immediately, without waiting for a clk edge.
